// File: rtl/diff_unit_if.sv
// Operand/result bundle for diff_unit: the operands come in from the
// requester, and both the combinational and the registered results go back.
interface diff_unit_if #(
  parameter int N = 8
);

  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         b_in;
  logic [N-1:0] d;
  logic         b_out;
  logic [N-1:0] d_q;
  logic         b_out_q;

  // Requester side: drives the operands and observes the results.
  modport master (
    output x, y, b_in,
    input  d, b_out, d_q, b_out_q
  );

  // Subtractor side: consumes the operands and produces the results.
  modport slave (
    input  x, y, b_in,
    output d, b_out, d_q, b_out_q
  );

endinterface

// File: rtl/diff_unit.sv
// diff_unit: N-bit unsigned ripple-borrow subtractor, d = x - y - b_in.
// A borrow-out of 1 means x < y + b_in, which is what the min-selection
// datapath muxes on. The result is also registered for pipelined consumers.
module diff_unit #(
  parameter int N = 8
) (
  input  logic        clock,
  input  logic        reset_,
  diff_unit_if.slave  bus
);

  logic [N-1:0] diff;
  logic         borrow;
  logic [N-1:0] dReg_d;
  logic [N-1:0] dReg_q;
  logic         bOutReg_d;
  logic         bOutReg_q;

  // Chain of full-subtractor cells, LSB first. 'borrow' carries the stage
  // borrow up the chain and holds the MSB borrow-out when the loop ends.
  always_comb begin
    diff   = '0;
    borrow = bus.b_in;
    for (int i = 0; i < N; i++) begin
      diff[i] = bus.x[i] ^ bus.y[i] ^ borrow;
      borrow  = (~bus.x[i] & bus.y[i]) | (~(bus.x[i] ^ bus.y[i]) & borrow);
    end
  end

  assign bus.d     = diff;
  assign bus.b_out = borrow;

  assign dReg_d    = diff;
  assign bOutReg_d = borrow;

  // Output register: captures the result every cycle, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      dReg_q    <= '0;
      bOutReg_q <= 1'b0;
    end else begin
      dReg_q    <= dReg_d;
      bOutReg_q <= bOutReg_d;
    end
  end

  assign bus.d_q     = dReg_q;
  assign bus.b_out_q = bOutReg_q;

endmodule

// File: tb/tb_diff_unit.sv
// Testbench for diff_unit: an 8-bit instance driven with directed cases and
// a 4-bit instance swept over every operand combination. Expected registered
// results are queued when the operands are driven and popped one cycle later.
module tb_diff_unit;

  logic clock;
  logic reset_;

  int checkCount;
  int passCount;

  logic [8:0] expQ8[$];
  logic [4:0] expQ4[$];

  diff_unit_if #(.N(8)) bus8 ();
  diff_unit_if #(.N(4)) bus4 ();

  diff_unit #(.N(8)) dut8 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus8.slave)
  );

  diff_unit #(.N(4)) dut4 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus4.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drives 8-bit operands mid-cycle, checks the combinational result and
  // queues the value the register should show after the next posedge.
  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] yv, input logic bv);
    logic [8:0] expVal;
    @(negedge clock);
    bus8.x    = xv;
    bus8.y    = yv;
    bus8.b_in = bv;
    expVal = {1'b0, xv} - {1'b0, yv} - {8'd0, bv};
    #1;
    checkOutput("d8",     {24'd0, bus8.d},  {24'd0, expVal[7:0]});
    checkOutput("bout8",  {31'd0, bus8.b_out}, {31'd0, expVal[8]});
    expQ8.push_back(expVal);
  endtask

  // Waits for the capturing edge and compares the registered 8-bit result.
  task automatic checkRegistered8();
    logic [8:0] expVal;
    @(posedge clock);
    #1;
    if (expQ8.size() == 0) begin
      checkOutput("queue8_empty", 32'd0, 32'd1);
    end else begin
      expVal = expQ8.pop_front();
      checkOutput("dq8",    {24'd0, bus8.d_q},     {24'd0, expVal[7:0]});
      checkOutput("boutq8", {31'd0, bus8.b_out_q}, {31'd0, expVal[8]});
    end
  endtask

  task automatic step8(input logic [7:0] xv, input logic [7:0] yv, input logic bv);
    applyStimulus(xv, yv, bv);
    checkRegistered8();
  endtask

  initial begin
    logic [4:0] exp4;
    logic [4:0] reg4;

    checkCount = 0;
    passCount  = 0;

    // Reset held across several edges; combinational path still live.
    reset_    = 1'b0;
    bus8.x    = 8'd9;
    bus8.y    = 8'd3;
    bus8.b_in = 1'b0;
    bus4.x    = 4'd0;
    bus4.y    = 4'd0;
    bus4.b_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_d8",     {24'd0, bus8.d},       32'h06);
    checkOutput("rst_bout8",  {31'd0, bus8.b_out},   32'h0);
    checkOutput("rst_dq8",    {24'd0, bus8.d_q},     32'h0);
    checkOutput("rst_boutq8", {31'd0, bus8.b_out_q}, 32'h0);
    checkOutput("rst_dq4",    {28'd0, bus4.d_q},     32'h0);
    @(negedge clock);
    reset_ = 1'b1;

    // Directed cases, including both boundaries.
    step8(8'h07, 8'h05, 1'b0);
    step8(8'h05, 8'h07, 1'b0);
    step8(8'h80, 8'h80, 1'b0);
    step8(8'h80, 8'h80, 1'b1);
    step8(8'h00, 8'hFF, 1'b1);
    step8(8'hFF, 8'h00, 1'b0);
    step8(8'h00, 8'h00, 1'b1);
    step8(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Back-to-back operands: register must lag by exactly one cycle.
    applyStimulus(8'h30, 8'h10, 1'b0);
    applyStimulus(8'h10, 8'h30, 1'b1);
    checkOutput("lag_dq8", {24'd0, bus8.d_q}, {24'd0, expQ8[0][7:0]});
    void'(expQ8.pop_front());
    checkRegistered8();

    // Mid-run reset: load a nonzero result, then clear it between edges.
    step8(8'h05, 8'h07, 1'b0);
    @(posedge clock);
    #2;
    reset_ = 1'b0;
    #1;
    checkOutput("midrst_dq8",    {24'd0, bus8.d_q},     32'h0);
    checkOutput("midrst_boutq8", {31'd0, bus8.b_out_q}, 32'h0);
    checkOutput("midrst_d8",     {24'd0, bus8.d},       32'hFE);
    @(posedge clock);
    #1;
    checkOutput("midrst_hold_dq8", {24'd0, bus8.d_q}, 32'h0);
    @(negedge clock);
    reset_ = 1'b1;
    expQ8.delete();
    step8(8'h09, 8'h03, 1'b0);

    // Exhaustive 4-bit sweep against a 5-bit reference subtraction.
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        for (int bi = 0; bi < 2; bi++) begin
          @(negedge clock);
          bus4.x    = 4'(xi);
          bus4.y    = 4'(yi);
          bus4.b_in = 1'(bi);
          exp4 = {1'b0, 4'(xi)} - {1'b0, 4'(yi)} - {4'd0, 1'(bi)};
          #1;
          checkOutput("sweep_comb4", {27'd0, bus4.b_out, bus4.d}, {27'd0, exp4});
          expQ4.push_back(exp4);
          @(posedge clock);
          #1;
          reg4 = expQ4.pop_front();
          checkOutput("sweep_reg4", {27'd0, bus4.b_out_q, bus4.d_q}, {27'd0, reg4});
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
